// File: rtl/md_pkg.sv
// Shared types and op-class decode for the MIPS multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101
    } md_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } md_state_t;

    // Op-class lookups indexed by the raw 3-bit op code; 110/111 belong to no class.
    localparam logic [7:0] IsMul    = 8'b0000_0011;
    localparam logic [7:0] IsDiv    = 8'b0000_1100;
    localparam logic [7:0] IsSigned = 8'b0000_0101;
    localparam logic [7:0] IsMt     = 8'b0011_0000;

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_if import md_pkg::*; #(
    parameter int unsigned WIDTH = 32
) ();

    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, flush,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, flush,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/md_negate.sv
// Combinational conditional two's-complement negate.
module md_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply (radix-2 shift-add) / restoring divide unit owning HI/LO.
// Operands are reduced to magnitudes on accept; signs are restored in the FIX cycle.
module md_unit import md_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    md_if.slave  bus
);

    localparam int unsigned     CntW     = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    md_state_t        state_q;
    logic [CntW-1:0]  cnt_q;
    logic             sa_q, sb_q, mul_q, dz_q;
    logic [WIDTH-1:0] a_raw_q, mb_q;
    logic [WIDTH-1:0] p_q, m_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;

    logic             op_md, sign_a, sign_b, start_ok;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        op_md    = IsMul[bus.op] | IsDiv[bus.op];
        sign_a   = IsSigned[bus.op] & bus.a[WIDTH-1];
        sign_b   = IsSigned[bus.op] & bus.b[WIDTH-1];
        start_ok = bus.start & ~bus.flush;
    end

    md_negate #(.WIDTH(WIDTH)) u_neg_a (
        .neg    (sign_a),
        .value  (bus.a),
        .result (mag_a)
    );

    md_negate #(.WIDTH(WIDTH)) u_neg_b (
        .neg    (sign_b),
        .value  (bus.b),
        .result (mag_b)
    );

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_shift, div_diff;
    logic             div_ge;

    // Remainder stays below |b| < 2^WIDTH, so one guard bit above the shifted value is the sign.
    always_comb begin
        mul_sum   = {1'b0, p_q} + (m_q[0] ? {1'b0, mb_q} : '0);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {2'b00, mb_q};
        div_ge    = ~div_diff[WIDTH+1];
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_negate #(.WIDTH(2 * WIDTH)) u_neg_prod (
        .neg    (sa_q ^ sb_q),
        .value  ({p_q, m_q}),
        .result (prod_fix)
    );

    md_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .neg    (sa_q ^ sb_q),
        .value  (quo_q),
        .result (quo_fix)
    );

    md_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .neg    (sa_q),
        .value  (rem_q[WIDTH-1:0]),
        .result (rem_fix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mul_q   <= 1'b0;
            dz_q    <= 1'b0;
            a_raw_q <= '0;
            mb_q    <= '0;
            p_q     <= '0;
            m_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok && op_md) begin
                        state_q <= StCalc;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        sa_q    <= sign_a;
                        sb_q    <= sign_b;
                        mul_q   <= IsMul[bus.op];
                        dz_q    <= (bus.b == '0);
                        a_raw_q <= bus.a;
                        mb_q    <= mag_b;
                        p_q     <= '0;
                        m_q     <= mag_a;
                        rem_q   <= '0;
                        quo_q   <= mag_a;
                    end else if (start_ok && IsMt[bus.op]) begin
                        if (bus.op == OpMthi) begin
                            hi_q <= bus.a;
                        end else begin
                            lo_q <= bus.a;
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        if (mul_q) begin
                            p_q <= mul_sum[WIDTH:1];
                            m_q <= {mul_sum[0], m_q[WIDTH-1:1]};
                        end else begin
                            rem_q <= div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
                            quo_q <= {quo_q[WIDTH-2:0], div_ge};
                        end
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastIter) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (mul_q) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (dz_q) begin
                            hi_q <= a_raw_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: cycle-level arithmetic model for WIDTH=32 plus a WIDTH=8 instance.
module tb_md_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    md_if #(.WIDTH(32)) bus32 ();
    md_if #(.WIDTH(8))  bus8 ();

    md_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    md_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of a mul/div, straight from integer arithmetic.
    function automatic void model_op(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        p  = '0;
        case (o)
            OpMult:  p = sx * sy;
            OpMultu: p = ux * uy;
            OpDiv, OpDivu: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == OpDiv) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p  = {sr[31:0], sq[31:0]};
                end else begin
                    sq = longint'(ux / uy);
                    sr = longint'(ux % uy);
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: p = '0;
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    // Model: `left` counts edges until the result lands; nonzero means an op is in flight.
    int          left = 0;
    logic [31:0] e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
    logic        e_busy = 1'b0, e_done = 1'b0;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        e_done = 1'b0;
        if (rst) begin
            left = 0;
            e_hi = '0;
            e_lo = '0;
            model_live = 1'b1;
        end else if (left > 0) begin
            if (bus32.flush) begin
                left = 0;
            end else begin
                left--;
                if (left == 0) begin
                    e_hi   = p_hi;
                    e_lo   = p_lo;
                    e_done = 1'b1;
                end
            end
        end else if (bus32.start && !bus32.flush) begin
            case (bus32.op)
                OpMult, OpMultu, OpDiv, OpDivu: begin
                    model_op(bus32.op, bus32.a, bus32.b, p_hi, p_lo);
                    left = 33;
                end
                OpMthi:  e_hi = bus32.a;
                OpMtlo:  e_lo = bus32.a;
                default: ;
            endcase
        end
        e_busy = (left > 0);
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("cyc_hi", bus32.hi, e_hi);
            chk("cyc_lo", bus32.lo, e_lo);
            chk("cyc_busy", 32'(bus32.busy), 32'(e_busy));
            chk("cyc_done", 32'(bus32.done), 32'(e_done));
        end
    end

    task automatic drive(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
        bus32.start = 1'b1;
        bus32.op    = o;
        bus32.a     = x;
        bus32.b     = y;
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic issue(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        drive(o, x, y);
    endtask

    // Called one negedge after the accept edge; counts negedges until done.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = bus32.busy ? 1 : 0;
        while (!bus32.done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus32.busy) busy_n++;
        end
    endtask

    task automatic run(input string name, input bit now, input md_op_t o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, busy_n;
        if (now) drive(o, x, y);
        else issue(o, x, y);
        wait_done(lat, busy_n);
        chk({name, "_lat"}, lat, 33);
        chk({name, "_busy_cycles"}, busy_n, 33);
        chk({name, "_hi"}, bus32.hi, exp_hi);
        chk({name, "_lo"}, bus32.lo, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        bus32.start = 1'b0; bus32.op = OpMult; bus32.a = '0; bus32.b = '0; bus32.flush = 1'b0;
        bus8.start  = 1'b0; bus8.op  = OpMult; bus8.a  = '0; bus8.b  = '0; bus8.flush  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_hi", bus32.hi, 32'h0);
        chk("rst_lo", bus32.lo, 32'h0);
        chk("rst_busy", 32'(bus32.busy), 32'h0);
        chk("rst_done", 32'(bus32.done), 32'h0);

        // WIDTH=8 multiply: latency WIDTH+1
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = OpMultu; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_lat", lat, 9);
        chk("w8_hi", 32'(bus8.hi), 32'h0000_00FE);
        chk("w8_lo", 32'(bus8.lo), 32'h0000_0001);

        run("multu_max", 1'b0, OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("mult_neg", 1'b0, OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run("mult_min", 1'b0, OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run("mult_nn", 1'b0, OpMult, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'h0, 32'h0000_002A);
        run("div_neg", 1'b0, OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu_100_7", 1'b0, OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);
        run("divu_zero", 1'b0, OpDivu, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run("div_ovf", 1'b0, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        issue(OpMthi, 32'h1234, 32'h0);
        chk("mthi_hi", bus32.hi, 32'h1234);
        chk("mthi_busy", 32'(bus32.busy), 32'h0);

        // Flush at cycle 10 with ignored start pulses during busy
        issue(OpMult, 32'd3, 32'd4);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            bus32.start = (i % 3 == 0);
            bus32.op    = OpMtlo;
            bus32.a     = 32'hDEAD;
        end
        bus32.start = 1'b0;
        bus32.flush = 1'b1;
        @(negedge clk);
        bus32.flush = 1'b0;
        chk("flush_busy", 32'(bus32.busy), 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done) seen++;
        end
        chk("flush_no_done", seen, 0);
        chk("flush_hi", bus32.hi, 32'h1234);
        chk("flush_lo", bus32.lo, 32'h8000_0000);

        issue(OpMtlo, 32'hCAFE, 32'h0);
        chk("mtlo_lo", bus32.lo, 32'hCAFE);
        chk("mtlo_done", 32'(bus32.done), 32'h0);
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = OpMtlo; bus32.a = 32'hBEEF; bus32.flush = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0; bus32.flush = 1'b0;
        chk("mtlo_flush_lo", bus32.lo, 32'hCAFE);

        // Flush in the FIX cycle suppresses the write
        issue(OpMultu, 32'd2, 32'd3);
        repeat (32) @(negedge clk);
        chk("fix_busy", 32'(bus32.busy), 32'h1);
        bus32.flush = 1'b1;
        @(negedge clk);
        bus32.flush = 1'b0;
        chk("fixflush_busy", 32'(bus32.busy), 32'h0);
        chk("fixflush_done", 32'(bus32.done), 32'h0);
        chk("fixflush_lo", bus32.lo, 32'hCAFE);

        issue(md_op_t'(3'b110), 32'd5, 32'd5);
        chk("op110_busy", 32'(bus32.busy), 32'h0);
        issue(md_op_t'(3'b111), 32'd9, 32'd9);
        chk("op111_hi", bus32.hi, 32'h1234);
        chk("op111_lo", bus32.lo, 32'hCAFE);

        // Back-to-back: second start presented in the done cycle
        run("b2b_first", 1'b0, OpMultu, 32'd6, 32'd7, 32'h0, 32'h0000_002A);
        run("b2b_second", 1'b1, OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);

        issue(OpDiv, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hi", bus32.hi, 32'h0);
        chk("midrst_lo", bus32.lo, 32'h0);
        chk("midrst_busy", 32'(bus32.busy), 32'h0);
        chk("midrst_done", 32'(bus32.done), 32'h0);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit for the MIPS execute stage. It owns the architectural HI/LO registers and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply uses iterative radix-2 shift-add and divide uses restoring division, both with a final sign-fix cycle. It sits beside the single-cycle ALU/shifter in EX, and the hazard unit uses `busy` to stall the pipeline while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only when `busy`=0 and `flush`=0.
- `op`  in  3  `md_op_t`: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTxx source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  pipeline flush; aborts the operation in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in flight; high in CALC and FIX.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are written by a mul/div.

## Operation
- Reset state: state IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0; iteration counter 0.
- States:
  - IDLE to CALC on an accepted mul/div `start`.
  - CALC to FIX after WIDTH iterations.
  - FIX to IDLE unconditionally.
- Accept in IDLE:
  - Latch sign flags. Signed ops only: `sa`=a[W-1], `sb`=b[W-1].
  - Latch magnitudes: |a| and |b|, two's-complement negate when the sign flag is set; unsigned ops use raw values.
  - Latch op class and a divide-by-zero flag (`b`==0).
- MULT/MULTU:
  - Holds a 2W-bit accumulator {P, M}; starts P=0, M=|a|.
  - Each CALC cycle: if M[0], P += |b| with carry into bit W; then shift {carry, P, M} right by 1.
- DIV/DIVU:
  - Holds a W+1-bit remainder R (starts 0) and quotient register Q (starts |a|).
  - Each CALC cycle: shift {R, Q} left by 1 and form T = R − |b|.
  - If T ≥ 0: R=T and Q[0]=1; otherwise R is kept and Q[0]=0.
- FIX (mul):
  - Writes {hi, lo} = product.
  - The product is negated (2W-bit) if `sa`^`sb`.
- FIX (div):
  - Writes lo = quotient, negated if `sa`^`sb`.
  - Writes hi = remainder, negated if `sa`.
  - Divide by zero overrides this: lo = all-ones, hi = original `a`, regardless of signedness.
  - Most-negative / −1 wraps naturally: lo = 2^(W−1) bit pattern, hi = 0.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - Writes `hi` / `lo` = `a` at the accepting edge.
  - No state change, no `busy`, no `done`.
- `start` while `busy`=1 is ignored; the hazard unit holds the instruction.
- Ops 110/111 are ignored entirely.
- Flush:
  - While `busy`, `flush` returns the unit to IDLE at the next edge.
  - HI/LO keep their prior values and no `done` is produced.
  - `flush` with `start` in the same cycle: the flush wins and the start is not accepted, including MTHI/MTLO.
  - `flush` in FIX: the write is suppressed.
- Reset mid-operation: same as a flush, and HI/LO are also cleared.

## Timing
- Cycle numbering: accept at edge E0; CALC spans E1..E_WIDTH; FIX write at E_(WIDTH+1).
- `busy` is registered: high from after E0 until after E_(WIDTH+1).
- `done` is registered: high for exactly the one cycle after E_(WIDTH+1), with new HI/LO visible in the same cycle.
- Latency from accept to `done` is WIDTH+1 cycles (33 for WIDTH=32).
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput of one op per WIDTH+2 cycles.
- `hi` and `lo` are direct register outputs with no combinational path from inputs.
- Iteration counter width is $clog2(WIDTH)+1; it never wraps within an op.

## Structure
- Package `md_pkg` holds:
  - `md_op_t` encoding;
  - `md_state_t` {IDLE, CALC, FIX};
  - localparams for the op-class decode (`is_mul`, `is_signed`, `is_mt`).
- Sub-module `md_negate #(WIDTH)`: combinational conditional two's-complement negate. It is instantiated for operand magnitude, the 2W-bit product fix (as WIDTH*2) and the quotient/remainder fix.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, `done` exactly 33 cycles after accept, `busy` high 33 cycles.
- MULT −3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7; DIV 0x80000000 / −1 -> lo=0x80000000, hi=0.
- With hi=0x1234 from MTHI, start MULT and assert `flush` at cycle 10 -> `busy` low next cycle, no `done`, hi stays 0x1234; `start` pulses during `busy` are ignored.
- MTLO 0xCAFE in IDLE -> lo=0xCAFE next cycle, `busy`/`done` stay 0; MTLO with simultaneous `flush` -> lo unchanged.
- `rst` asserted mid-DIV -> next cycle hi=lo=0, `busy`=0, `done`=0; repeat the MULTU case with WIDTH=8 (0xFF×0xFF -> hi=0xFE, lo=0x01, latency 9).
